// File: rtl/axi4_frame_writer_pkg.sv
// Shared types and AXI constants for the frame writer.
// Holds the FSM state encoding and an AWSIZE helper.
package axi_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] BURST_INCR           = 2'b01;
    localparam logic [3:0] CACHE_BUFFERABLE_MOD = 4'b0011;
    localparam logic [1:0] RESP_OKAY            = 2'b00;

    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/axi4_frame_writer_if.sv
// AXI4 write-only bus (AW, W, B channels) between writer and memory.
// master: drives AW/W payload, valid and BREADY; slave: the responder.
interface axi4_frame_writer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0]   AWADDR;
    logic                AWVALID;
    logic                AWREADY;
    logic [7:0]          AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic [3:0]          AWCACHE;
    logic [2:0]          AWPROT;
    logic [DATA_W-1:0]   WDATA;
    logic                WVALID;
    logic                WREADY;
    logic                WLAST;
    logic [DATA_W/8-1:0] WSTRB;
    logic                BVALID;
    logic                BREADY;
    logic [1:0]          BRESP;

    modport master (
        output AWADDR, AWVALID, AWLEN, AWSIZE, AWBURST, AWCACHE, AWPROT,
        output WDATA, WVALID, WLAST, WSTRB, BREADY,
        input  AWREADY, WREADY, BVALID, BRESP
    );

    modport slave (
        input  AWADDR, AWVALID, AWLEN, AWSIZE, AWBURST, AWCACHE, AWPROT,
        input  WDATA, WVALID, WLAST, WSTRB, BREADY,
        output AWREADY, WREADY, BVALID, BRESP
    );
endinterface

// File: rtl/axi4_frame_writer_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
// Ports: push/din in, pop/dout out (dout valid when !empty), full, level.
module sync_fifo_fwft #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 512
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit so full and empty stay distinct.
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ONE;
            if (do_pop)  rd_ptr <= rd_ptr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/axi4_frame_writer.sv
// Stream-to-AXI4 frame writer: buffers beats, writes INCR bursts into
// NUM_BUFS rotating frame buffers, reports the last completed buffer.
// Ports: s_* stream in, axi master bus, frame_done/buf indices, errors.
module axi4_frame_writer
    import axi_frame_pkg::*;
#(
    parameter int          AXI_ADDR_WIDTH = 32,
    parameter int          AXI_DATA_WIDTH = 64,
    parameter int          BURST_LEN      = 64,
    parameter int          FRAME_BYTES    = 153600,
    parameter int          NUM_BUFS       = 3,
    parameter logic [31:0] BUF_STRIDE     = 32'h0010_0000,
    parameter int          FIFO_DEPTH     = 512
) (
    input  logic                          clk_100Mhz,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [AXI_ADDR_WIDTH-1:0]     FRAME_BASE_ADDR,
    input  logic [AXI_DATA_WIDTH-1:0]     s_data,
    input  logic                          s_valid,
    input  logic                          s_sof,
    output logic                          s_ready,
    axi4_frame_writer_if.master           axi,
    output logic                          frame_done,
    output logic [1:0]                    wr_buf_idx,
    output logic [1:0]                    rd_buf_idx,
    input  logic                          err_clear,
    output logic                          bresp_err,
    output logic                          frame_err,
    output logic                          drop_err,
    output logic [1:0]                    state,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW  = AXI_ADDR_WIDTH;
    localparam int DW  = AXI_DATA_WIDTH;
    localparam int BURST_BYTES = BURST_LEN * DW / 8;
    localparam int BURSTS = FRAME_BYTES / BURST_BYTES;
    localparam int BCW = $clog2(BURSTS + 1);
    localparam int CW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BCW-1:0] LAST_BURST = BCW'(BURSTS - 1);
    localparam logic [CW-1:0]  LAST_BEAT  = CW'(BURST_LEN - 1);
    localparam logic [LW-1:0]  LAUNCH_LVL = LW'(BURST_LEN);
    localparam logic [1:0]     LAST_BUF   = 2'(NUM_BUFS - 1);

    state_t         state_q, state_d;
    logic [BCW-1:0] burst_cnt;
    logic [CW-1:0]  beat_cnt;
    logic           need_sof;
    logic           en_q;
    logic [AW-1:0]  aw_addr;
    logic [AW-1:0]  buf_base;
    logic [AW-1:0]  base_now;
    logic [AW-1:0]  launch_addr;

    logic           push, pop, full, empty;
    logic [DW:0]    head;
    logic           head_sof;
    logic           en_rise, discard, resync, launch;
    logic           w_fire, b_fire, w_last, frame_end;

    assign s_ready  = !full;
    assign push     = s_valid && s_ready;
    assign head_sof = head[DW];

    sync_fifo_fwft #(
        .WIDTH (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_100Mhz),
        .rst_n (rst_n),
        .push  (push),
        .din   ({s_sof, s_data}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign en_rise   = enable && !en_q;
    assign w_last    = (beat_cnt == LAST_BEAT);
    assign frame_end = (burst_cnt == LAST_BURST);
    assign w_fire    = (state_q == DATA) && axi.WREADY;
    assign b_fire    = (state_q == RESP) && axi.BVALID;

    // Head-of-queue decisions are only taken between bursts.
    assign discard = (state_q == IDLE) && need_sof && !empty && !head_sof;
    assign resync  = (state_q == IDLE) && !empty && head_sof
                     && (burst_cnt != '0);
    // A full burst must be buffered so W never stalls on our side.
    assign launch  = (state_q == IDLE) && enable && !en_rise && !resync
                     && (fifo_level >= LAUNCH_LVL)
                     && (!need_sof || head_sof);

    // Buffer base is recomputed at the first burst of each frame.
    assign base_now = (burst_cnt == '0)
        ? FRAME_BASE_ADDR + AW'(wr_buf_idx) * AW'(BUF_STRIDE)
        : buf_base;
    assign launch_addr = base_now + AW'(burst_cnt) * AW'(BURST_BYTES);

    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                pop = discard;
                if (launch) state_d = ADDR;
            end
            ADDR: if (axi.AWREADY) state_d = DATA;
            DATA: begin
                pop = axi.WREADY;
                if (axi.WREADY && w_last) state_d = RESP;
            end
            RESP: if (axi.BVALID) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            aw_addr    <= '0;
            buf_base   <= '0;
            burst_cnt  <= '0;
            beat_cnt   <= '0;
            need_sof   <= 1'b1;
            en_q       <= 1'b0;
            frame_done <= 1'b0;
            wr_buf_idx <= 2'd0;
            rd_buf_idx <= LAST_BUF;
            bresp_err  <= 1'b0;
            frame_err  <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            en_q       <= enable;
            frame_done <= 1'b0;
            if (launch) begin
                aw_addr  <= launch_addr;
                buf_base <= base_now;
                need_sof <= 1'b0;
                beat_cnt <= '0;
            end
            if (w_fire) beat_cnt <= beat_cnt + 1'b1;
            if (resync) burst_cnt <= '0;
            if (b_fire) begin
                if (frame_end) begin
                    burst_cnt  <= '0;
                    frame_done <= 1'b1;
                    rd_buf_idx <= wr_buf_idx;
                    wr_buf_idx <= (wr_buf_idx == LAST_BUF)
                                  ? 2'd0 : wr_buf_idx + 2'd1;
                end else begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end
            // Re-enable restarts cleanly at the next frame boundary.
            if (en_rise) begin
                need_sof  <= 1'b1;
                burst_cnt <= '0;
            end
            bresp_err <= (bresp_err && !err_clear)
                         || (b_fire && axi.BRESP != RESP_OKAY);
            frame_err <= (frame_err && !err_clear) || resync
                         || (w_fire && head_sof && beat_cnt != '0);
            drop_err  <= (drop_err && !err_clear) || (s_valid && !s_ready);
        end
    end

    assign state       = state_q;
    assign axi.AWADDR  = aw_addr;
    assign axi.AWVALID = (state_q == ADDR);
    assign axi.AWLEN   = 8'(BURST_LEN - 1);
    assign axi.AWSIZE  = axi_size(DW);
    assign axi.AWBURST = BURST_INCR;
    assign axi.AWCACHE = CACHE_BUFFERABLE_MOD;
    assign axi.AWPROT  = 3'b000;
    assign axi.WDATA   = head[DW-1:0];
    assign axi.WVALID  = (state_q == DATA);
    assign axi.WLAST   = (state_q == DATA) && w_last;
    assign axi.WSTRB   = '1;
    assign axi.BREADY  = (state_q == RESP);
endmodule

// File: tb/tb_axi4_frame_writer.sv
// Bench for axi4_frame_writer: stream driver, AXI slave responder,
// reference model feeding AW/W/done scoreboards.
module tb_axi4_frame_writer;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int BL = 4;
    localparam int FB = 128;
    localparam int NB = 3;
    localparam int FD = 512;
    localparam int BPF = FB / (BL * DW / 8);
    localparam logic [31:0] STRIDE = 32'h100;
    localparam logic [31:0] BASE   = 32'h1000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [AW-1:0] base_addr = BASE;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_sof = 1'b0;
    logic          s_ready;
    logic          frame_done;
    logic [1:0]    wr_buf_idx, rd_buf_idx, state;
    logic          err_clear = 1'b0;
    logic          bresp_err, frame_err, drop_err;
    logic [9:0]    fifo_level;

    axi4_frame_writer_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

    axi4_frame_writer #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .BURST_LEN      (BL),
        .FRAME_BYTES    (FB),
        .NUM_BUFS       (NB),
        .BUF_STRIDE     (STRIDE),
        .FIFO_DEPTH     (FD)
    ) dut (
        .clk_100Mhz      (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .FRAME_BASE_ADDR (base_addr),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_sof           (s_sof),
        .s_ready         (s_ready),
        .axi             (axi),
        .frame_done      (frame_done),
        .wr_buf_idx      (wr_buf_idx),
        .rd_buf_idx      (rd_buf_idx),
        .err_clear       (err_clear),
        .bresp_err       (bresp_err),
        .frame_err       (frame_err),
        .drop_err        (drop_err),
        .state           (state),
        .fifo_level      (fifo_level)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboards
    logic [31:0] exp_aw [$];
    logic [64:0] exp_w [$];
    logic [3:0]  exp_done [$];

    // Reference model state
    int          m_buf, m_burst, pend_n;
    bit          m_need_sof;
    bit          exp_ferr;
    logic [63:0] pend [BL];
    int          accepted;
    logic [9:0]  lvl_seen;
    logic [63:0] seq = 64'h5A00_0000_0000_0000;

    task automatic model_beat(input logic [63:0] d, input logic sof);
        if (pend_n == 0) begin
            if (m_need_sof) begin
                if (!sof) return;
                m_need_sof = 1'b0;
            end else if (sof && m_burst != 0) begin
                m_burst  = 0;
                exp_ferr = 1'b1;
            end
        end else if (sof) begin
            exp_ferr = 1'b1;
        end
        pend[pend_n] = d;
        pend_n++;
        if (pend_n == BL) begin
            exp_aw.push_back(BASE + 32'(m_buf) * STRIDE + 32'(m_burst * 32));
            for (int i = 0; i < BL; i++)
                exp_w.push_back({i == BL - 1, pend[i]});
            pend_n = 0;
            m_burst++;
            if (m_burst == BPF) begin
                exp_done.push_back({2'(m_buf), 2'((m_buf + 1) % NB)});
                m_buf   = (m_buf + 1) % NB;
                m_burst = 0;
            end
        end
    endtask

    task automatic send(input logic [63:0] d, input logic sof,
                        output logic acc);
        @(negedge clk);
        s_valid  = 1'b1;
        s_data   = d;
        s_sof    = sof;
        acc      = s_ready;
        lvl_seen = fifo_level;
        @(posedge clk);
        if (acc) begin
            accepted++;
            model_beat(d, sof);
        end
    endtask

    task automatic send_frame(input int n);
        logic acc;
        for (int i = 0; i < n; i++) begin
            send(seq, i == 0, acc);
            seq++;
        end
    endtask

    task automatic stop_stream();
        @(negedge clk);
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    // AXI slave responder
    int aw_delay = 0;
    bit w_rand = 1'b0;
    bit w_stall = 1'b0;
    int bcount = 0;
    int slverr_at = -1;

    task automatic serve();
        logic [31:0] a;
        logic [64:0] e;
        logic        wr;
        int          beats, guard;
        a = axi.AWADDR;
        for (int i = 0; i < aw_delay; i++) begin
            @(negedge clk);
            check("aw_hold", 64'({axi.AWVALID, axi.AWADDR}), 64'({1'b1, a}));
        end
        axi.AWREADY = 1'b1;
        if (exp_aw.size() == 0) check("aw_extra", 64'(a), 64'(0));
        else check("awaddr", 64'(a), 64'(exp_aw.pop_front()));
        @(negedge clk);
        axi.AWREADY = 1'b0;
        beats = 0;
        guard = 0;
        while (beats < BL && guard < 5000) begin
            wr = w_stall ? 1'b0 : (w_rand ? 1'($urandom_range(0, 1)) : 1'b1);
            axi.WREADY = wr;
            if (wr && axi.WVALID) begin
                e = (exp_w.size() != 0) ? exp_w.pop_front() : '1;
                check("wdata", axi.WDATA, e[63:0]);
                check("wlast", 64'(axi.WLAST), 64'(e[64]));
                beats++;
            end
            @(negedge clk);
            guard++;
        end
        if (beats < BL) check("w_timeout", 64'(beats), 64'(BL));
        axi.WREADY = 1'b0;
        axi.BRESP  = (bcount == slverr_at) ? 2'b10 : 2'b00;
        axi.BVALID = 1'b1;
        guard = 0;
        while (!axi.BREADY && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("bready", 64'(axi.BREADY), 64'(1));
        @(negedge clk);
        axi.BVALID = 1'b0;
        axi.BRESP  = 2'b00;
        bcount++;
    endtask

    initial begin
        axi.AWREADY = 1'b0;
        axi.WREADY  = 1'b0;
        axi.BVALID  = 1'b0;
        axi.BRESP   = 2'b00;
        forever begin
            @(negedge clk);
            if (axi.AWVALID === 1'b1) serve();
        end
    end

    always @(negedge clk) begin : done_mon
        logic [3:0] e;
        if (rst_n && frame_done === 1'b1) begin
            if (exp_done.size() == 0) begin
                check("done_extra", 64'(frame_done), 64'(0));
            end else begin
                e = exp_done.pop_front();
                check("rd_buf", 64'(rd_buf_idx), 64'(e[3:2]));
                check("wr_buf", 64'(wr_buf_idx), 64'(e[1:0]));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        repeat (3) @(negedge clk);
        m_buf = 0; m_burst = 0; pend_n = 0;
        m_need_sof = 1'b1; exp_ferr = 1'b0; accepted = 0;
        exp_aw.delete(); exp_w.delete(); exp_done.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        stop_stream();
        while ((exp_aw.size() != 0 || exp_w.size() != 0 ||
                exp_done.size() != 0 || state != 2'd0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_drained"},
              64'(exp_aw.size() + exp_w.size() + exp_done.size()), 64'(0));
        check({tag, "_idle"}, 64'(state), 64'(0));
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
    endtask

    initial begin : main
        logic acc;
        bit   seen_full;
        enable = 1'b1;
        do_reset();
        check("rst_state", 64'(state), 64'(0));
        check("rst_awvalid", 64'(axi.AWVALID), 64'(0));
        check("rst_wvalid", 64'(axi.WVALID), 64'(0));
        check("rst_wlast", 64'(axi.WLAST), 64'(0));
        check("rst_bready", 64'(axi.BREADY), 64'(0));
        check("rst_awaddr", 64'(axi.AWADDR), 64'(0));
        check("rst_done", 64'(frame_done), 64'(0));
        check("rst_wrbuf", 64'(wr_buf_idx), 64'(0));
        check("rst_rdbuf", 64'(rd_buf_idx), 64'(NB - 1));
        check("rst_errs", 64'({bresp_err, frame_err, drop_err}), 64'(0));
        check("rst_level", 64'(fifo_level), 64'(0));
        check("rst_ready", 64'(s_ready), 64'(1));
        check("awlen", 64'(axi.AWLEN), 64'(BL - 1));
        check("awsize", 64'(axi.AWSIZE), 64'(3));
        check("awburst", 64'(axi.AWBURST), 64'(1));
        check("awcache", 64'(axi.AWCACHE), 64'(3));
        check("awprot", 64'(axi.AWPROT), 64'(0));
        check("wstrb", 64'(axi.WSTRB), 64'(8'hFF));

        // Three back-to-back frames, buffer rotation
        repeat (3) send_frame(16);
        drain("t1");
        check("t1_ferr", 64'(frame_err), 64'(exp_ferr));
        check("t1_wrbuf", 64'(wr_buf_idx), 64'(m_buf));

        // Leading beats without sof are discarded
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(seq, 1'b0, acc);
            seq++;
        end
        send_frame(16);
        drain("t2");
        check("t2_level", 64'(fifo_level), 64'(0));

        // Short frame followed by a new sof
        do_reset();
        send_frame(8);
        send_frame(16);
        drain("t3");
        check("t3_ferr", 64'(frame_err), 64'(exp_ferr));
        check("t3_wrbuf", 64'(wr_buf_idx), 64'(m_buf));
        pulse_clear();
        check("t3_ferr_clr", 64'(frame_err), 64'(0));

        // Delayed AWREADY and random WREADY
        do_reset();
        aw_delay = 7;
        w_rand   = 1'b1;
        repeat (2) send_frame(16);
        drain("t4");
        aw_delay = 0;
        w_rand   = 1'b0;

        // SLVERR on the second burst
        do_reset();
        slverr_at = bcount + 1;
        send_frame(16);
        drain("t5");
        slverr_at = -1;
        check("t5_bresp_err", 64'(bresp_err), 64'(1));
        pulse_clear();
        check("t5_bresp_clr", 64'(bresp_err), 64'(0));

        // Overflow while W is stalled, then drain
        do_reset();
        w_stall   = 1'b1;
        seen_full = 1'b0;
        for (int i = 0; i < 600; i++) begin
            send(seq, (i % 16) == 0, acc);
            seq++;
            if (!acc && !seen_full) begin
                seen_full = 1'b1;
                check("t6_full_lvl", 64'(lvl_seen), 64'(FD));
                check("t6_accepted", 64'(accepted), 64'(FD));
            end
        end
        stop_stream();
        check("t6_seen_full", 64'(seen_full), 64'(1));
        check("t6_ready_low", 64'(s_ready), 64'(0));
        check("t6_drop_err", 64'(drop_err), 64'(1));
        w_stall = 1'b0;
        drain("t6");
        check("t6_drop_sticky", 64'(drop_err), 64'(1));
        pulse_clear();
        check("t6_drop_clr", 64'(drop_err), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axi4_frame_writer.md
Name: axi4_frame_writer

Overview:
Parametrised stream-to-memory-mapped write engine. It is the single-clock successor of the camera-path DDR writer. It accepts a pixel-beat stream that is already in the AXI clock domain, buffers it, and writes fixed-length INCR bursts through an AXI4 write master into one of NUM_BUFS rotating frame buffers. It sits between the chroma-key mixer / width-packer and the PS HP port, and tells the HDMI reader which buffer was completed last.

Parameters:
AXI_ADDR_WIDTH, 32, AXI address width
AXI_DATA_WIDTH, 64, AXI/stream data width; must be a power of 2 and ≥32
BURST_LEN, 64, beats per burst, 1..256; BURST_BYTES = BURST_LEN*AXI_DATA_WIDTH/8, must be ≤4096
FRAME_BYTES, 153600, bytes per frame; must be a multiple of BURST_BYTES
NUM_BUFS, 3, number of frame buffers, 1..4
BUF_STRIDE, 32'h0010_0000, byte distance between buffers; must be ≥FRAME_BYTES
FIFO_DEPTH, 512, internal FIFO depth in beats; must be ≥2*BURST_LEN and a power of 2

Ports:
clk_100Mhz  in  1  system/AXI clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run control
FRAME_BASE_ADDR  in  AXI_ADDR_WIDTH  buffer 0 base address; must be BURST_BYTES-aligned
s_data  in  AXI_DATA_WIDTH  stream beat
s_valid  in  1  beat valid
s_sof  in  1  first beat of a frame; qualified by s_valid
s_ready  out  1  = !fifo_full
AWADDR, AWVALID, AWREADY, AWLEN[7:0], AWSIZE[2:0], AWBURST[1:0], AWCACHE[3:0], AWPROT[2:0]  AXI4 AW channel
WDATA, WVALID, WREADY, WLAST, WSTRB[AXI_DATA_WIDTH/8]  AXI4 W channel
BVALID, BREADY, BRESP[1:0]  AXI4 B channel
frame_done  out  1  one-cycle pulse when the last burst of a frame receives its response
wr_buf_idx  out  2  buffer currently being written
rd_buf_idx  out  2  last completed buffer
err_clear  in  1  clears the sticky error flags
bresp_err, frame_err, drop_err  out  1 each  sticky error flags
state  out  2  FSM state, for debug
fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Constant outputs: AWLEN=BURST_LEN-1; AWSIZE=log2(AXI_DATA_WIDTH/8); AWBURST=INCR; AWCACHE=4'b0011; AWPROT=0; WSTRB all ones.
- FIFO: entries are {sof, data}, first-word-fall-through. Push when s_valid && s_ready. If s_valid && !s_ready, set drop_err and discard the beat.
- Reset values: state=IDLE; AWVALID=WVALID=WLAST=BREADY=0; AWADDR=0; frame_done=0; wr_buf_idx=0; rd_buf_idx=NUM_BUFS-1; all error flags=0; burst_cnt=0; beat_cnt=0; FIFO empty; need_sof=1.
- FSM has four states: IDLE, ADDR, DATA, RESP.
- IDLE, discard case: if need_sof, the FIFO is not empty, and the head beat has sof=0, pop one beat per cycle and write nothing.
- IDLE, SOF resync case: if the head beat has sof=1 and burst_cnt≠0, the previous frame was short. Set frame_err, set burst_cnt=0, and keep wr_buf_idx so the same buffer is overwritten.
- IDLE, launch condition: enable && fifo_level≥BURST_LEN && (!need_sof || head sof=1).
- IDLE, launch actions: register AWADDR = base + wr_buf_idx*BUF_STRIDE + burst_cnt*BURST_BYTES. The base is latched when burst_cnt=0. Clear need_sof, then go to ADDR.
- ADDR: AWVALID=1 until AWREADY is sampled high, then go to DATA. AWVALID must not drop before the handshake.
- DATA, handshake: WVALID is held at 1; the whole burst is already buffered, so there are no bubbles. WDATA is the FIFO head. Pop on WVALID&&WREADY.
- DATA, beat counting: WLAST=1 exactly on beat_cnt=BURST_LEN-1. After that beat's handshake, WVALID=0 and the FSM goes to RESP.
- DATA, stray SOF: a beat with sof=1 at beat_cnt≠0 sets frame_err. The beat is still written.
- RESP: BREADY=1 only in this state. On BVALID:
  - if BRESP≠OKAY, set bresp_err;
  - burst_cnt++;
  - if that was the last burst of the frame: pulse frame_done, rd_buf_idx←wr_buf_idx, wr_buf_idx←(wr_buf_idx+1) mod NUM_BUFS, burst_cnt←0.
  - Then go to IDLE.
- Latency: with AWREADY and WREADY tied high, launch to first W beat takes 2 cycles, and one burst occupies BURST_LEN+3 cycles excluding B latency.
- enable deassert mid-burst: the current burst completes through RESP, because AXI cannot abort. The FSM then parks in IDLE and the FIFO keeps filling. The enable 0→1 edge sets need_sof=1 and burst_cnt=0.
- err_clear clears all sticky flags. If err_clear and a set event occur in the same cycle, the set wins.
- rst_n asserted mid-burst drops every output at once. A system reset of the interconnect is required alongside it.

Decomposition:
- Package axi_frame_pkg holds:
  - the state encoding (IDLE=0, ADDR=1, DATA=2, RESP=3);
  - AXI constants BURST_INCR, CACHE_BUFFERABLE_MOD=4'b0011, RESP_OKAY;
  - a function computing AWSIZE from the data width.
- Sub-module sync_fifo_fwft: width AXI_DATA_WIDTH+1, depth FIFO_DEPTH, with level output.

Test Plan:
1. BURST_LEN=4, FRAME_BYTES=128, NUM_BUFS=3, base 0x1000_0000, stride 0x100, ready signals tied high, three 16-beat frames with sof on beat 0:
   - 12 bursts at AWADDR 0x1000_0000, +0x20, +0x40, +0x60, then 0x1000_0100, …
   - frame_done pulses 3×, rd_buf_idx sequence 0,1,2.
2. Stream starts with 5 beats with sof=0, then a proper frame -> the 5 beats are discarded with no AW; first AWADDR = base.
3. A second sof arrives after 8 of 16 beats -> frame_err=1, the next burst is written at buffer 0 offset 0, and wr_buf_idx is unchanged.
4. WREADY toggled 1/0 randomly and AWREADY delayed 7 cycles -> AWVALID is stable until accepted, and WLAST appears only on the 4th accepted beat of each burst.
5. BRESP=SLVERR on burst 2 -> bresp_err=1 and the frame still completes. err_clear pulse -> flag returns to 0.
6. WREADY=0 for 600 cycles while 600 beats are offered -> s_ready falls at 512 and drop_err=1. Releasing WREADY -> the remaining FIFO data drains correctly.
